dot_prod_feeder: RTL and testbench
==================================

Name: dot_prod_feeder

Overview:
- Producer for dot_prod_pip; drives its x/y input streams.
- Buffers a reference vector of `length` complex samples and a signal window of `length+shifts-1` complex samples.
- On `start`, streams `shifts` back-to-back vector pairs: x = ref[k], y = sig[s+k] for k = 0..length-1, s = 0..shifts-1.
- Feeds one CAF delay slice of correlations to the downstream dot-product accumulator.

Parameters:
- xi_bits, 12, reference I width
- xq_bits, 12, reference Q width
- yi_bits, 12, signal I width
- yq_bits, 12, signal Q width
- length, 5, dot-product vector length (>=2)
- shifts, 4, number of delay offsets per run (>=1); signal depth localparam sig_len = length+shifts-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_ref_tvalid  in  1  reference sample valid
- ref_i  in  xi_bits  reference I
- ref_q  in  xq_bits  reference Q
- s_axis_ref_tready  out  1  reference buffer accepting
- s_axis_sig_tvalid  in  1  signal sample valid
- sig_i  in  yi_bits  signal I
- sig_q  in  yq_bits  signal Q
- s_axis_sig_tready  out  1  signal buffer accepting
- start  in  1  begin streaming (sampled only in READY)
- m_axis_product_tready  in  1  downstream accepts current x/y pair
- m_axis_x_tvalid  out  1  x pair valid
- xi  out  xi_bits  x I
- xq  out  xq_bits  x Q
- m_axis_y_tvalid  out  1  y pair valid (always equal to m_axis_x_tvalid)
- yi  out  yi_bits  y I
- yq  out  yq_bits  y Q
- shift_index  out  clog2(shifts)+1  current offset s
- last  out  1  high with the final pair (k=length-1) of each vector
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after final pair accepted

Behaviour:
- Reset (async, rst_n=0): state LOAD; all outputs 0; ref/sig write counters 0; buffer contents undefined. Reset mid-STREAM aborts immediately, with no done pulse.
- States: LOAD, READY, STREAM, DONE.
- LOAD:
  - s_axis_ref_tready = (ref_cnt < length).
  - s_axis_sig_tready = (sig_cnt < sig_len).
  - A sample is written at index cnt when valid&&ready; the two ports are independent and may fire in the same cycle.
  - Go to READY the cycle after both counters are full.
- READY: both treadys low; start=1 -> STREAM with s=0, k=0. start is ignored in every other state.
- STREAM:
  - First pair registered onto outputs; valid rises the cycle after start is sampled (latency 1).
  - Pair (s,k) is held stable while m_axis_product_tready=0.
  - On a valid&&tready cycle, advance in the next cycle: k+1, or wrap k=0 and s+1 at k=length-1.
  - No bubbles between pairs or between vectors while tready stays high.
  - last = valid && k==length-1; shift_index = s.
  - Acceptance of pair (shifts-1, length-1) -> DONE; valid drops next cycle.
- DONE: done=1 for one cycle, counters clear, then LOAD. Buffers must be fully reloaded before the next run.
- Data: pure copy of buffered samples, no arithmetic. x/y fields are 0 whenever valid=0.
- Total accepted pairs per run = length*shifts.

Test Plan:
- Reset, then load ref = (1+1j..5+5j) and sig = (10..17)+0j; assert start with tready=1 -> valid rises 1 cycle later; 20 consecutive pairs; s=2,k=0 gives x=1+1j, y=12; last asserted on cycles 5, 10, 15, 20; done pulses once.
- Same load, tready toggled 1,0,1,0 -> each pair held across the low cycles; sequence identical to the first case; done only after the 20th acceptance.
- Load sig before ref, with sig valid gaps -> READY entered only after the 5th ref and 8th sig sample; 9th sig beat sees tready=0.
- Assert start in LOAD (ref 3/5 loaded) -> ignored, busy stays 0; later start in READY is accepted normally.
- rst_n=0 at pair s=1,k=3 -> outputs 0 at once (async); state LOAD; ref and sig treadys 1 after release; no done pulse.
- shifts=1, length=2 -> exactly 2 pairs; last on the 2nd; done one cycle after its acceptance.

Source files
------------

// File: rtl/dot_prod_feeder_if.sv
// rtl/dot_prod_feeder_if.sv - sample input streams and x/y pair output stream of dot_prod_feeder
interface dot_prod_feeder_if #(
    parameter int xi_bits = 12,
    parameter int xq_bits = 12,
    parameter int yi_bits = 12,
    parameter int yq_bits = 12,
    parameter int shifts  = 4
);
    localparam int sh_bits = $clog2(shifts) + 1;

    // reference sample stream
    logic               s_axis_ref_tvalid;
    logic [xi_bits-1:0] ref_i;
    logic [xq_bits-1:0] ref_q;
    logic               s_axis_ref_tready;

    // signal sample stream
    logic               s_axis_sig_tvalid;
    logic [yi_bits-1:0] sig_i;
    logic [yq_bits-1:0] sig_q;
    logic               s_axis_sig_tready;

    // x/y pair stream towards the dot-product accumulator
    logic               m_axis_product_tready;
    logic               m_axis_x_tvalid;
    logic [xi_bits-1:0] xi;
    logic [xq_bits-1:0] xq;
    logic               m_axis_y_tvalid;
    logic [yi_bits-1:0] yi;
    logic [yq_bits-1:0] yq;
    logic [sh_bits-1:0] shift_index;
    logic               last;

    // feeder side
    modport master (
        input  s_axis_ref_tvalid, ref_i, ref_q,
        output s_axis_ref_tready,
        input  s_axis_sig_tvalid, sig_i, sig_q,
        output s_axis_sig_tready,
        input  m_axis_product_tready,
        output m_axis_x_tvalid, xi, xq, m_axis_y_tvalid, yi, yq, shift_index, last
    );

    // sample sources and pair consumer side
    modport slave (
        output s_axis_ref_tvalid, ref_i, ref_q,
        input  s_axis_ref_tready,
        output s_axis_sig_tvalid, sig_i, sig_q,
        input  s_axis_sig_tready,
        output m_axis_product_tready,
        input  m_axis_x_tvalid, xi, xq, m_axis_y_tvalid, yi, yq, shift_index, last
    );
endinterface

// File: rtl/dot_prod_feeder.sv
// rtl/dot_prod_feeder.sv - buffers ref/sig vectors and streams shifted x/y pairs to dot_prod_pip
module dot_prod_feeder #(
    parameter int xi_bits = 12,
    parameter int xq_bits = 12,
    parameter int yi_bits = 12,
    parameter int yq_bits = 12,
    parameter int length  = 5,
    parameter int shifts  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    dot_prod_feeder_if.master  bus
);
    localparam int sig_len = length + shifts - 1;
    localparam int KW      = $clog2(length);
    localparam int SIW     = $clog2(sig_len);
    localparam int SW      = $clog2(shifts) + 1;
    localparam int RCW     = $clog2(length + 1);
    localparam int SCW     = $clog2(sig_len + 1);

    localparam logic [RCW-1:0] REF_FULL = RCW'(length);
    localparam logic [SCW-1:0] SIG_FULL = SCW'(sig_len);
    localparam logic [KW-1:0]  K_LAST   = KW'(length - 1);
    localparam logic [SW-1:0]  S_LAST   = SW'(shifts - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_READY  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic [SCW-1:0] sig_cnt_q, sig_cnt_d;
    logic           ref_tready_q, ref_tready_d;
    logic           sig_tready_q, sig_tready_d;
    logic [SW-1:0]  s_q, s_d;
    logic [KW-1:0]  k_q, k_d;
    logic           valid_q, valid_d;
    logic [xi_bits-1:0] xi_q, xi_d;
    logic [xq_bits-1:0] xq_q, xq_d;
    logic [yi_bits-1:0] yi_q, yi_d;
    logic [yq_bits-1:0] yq_q, yq_d;

    logic [xi_bits-1:0] ref_i_buf [length];
    logic [xq_bits-1:0] ref_q_buf [length];
    logic [yi_bits-1:0] sig_i_buf [sig_len];
    logic [yq_bits-1:0] sig_q_buf [sig_len];

    logic           ref_we;
    logic           sig_we;
    logic           accept;
    logic [SIW-1:0] sig_rd_idx;

    // Handshake qualifiers: tready flops already encode "in LOAD and not full"
    always_comb begin
        ref_we = (state_q == ST_LOAD) && bus.s_axis_ref_tvalid && ref_tready_q;
        sig_we = (state_q == ST_LOAD) && bus.s_axis_sig_tvalid && sig_tready_q;
        accept = valid_q && bus.m_axis_product_tready;
    end

    // Sample buffers; contents are don't-care until reloaded, so no reset
    always_ff @(posedge clk) begin
        if (ref_we) begin
            ref_i_buf[KW'(ref_cnt_q)] <= bus.ref_i;
            ref_q_buf[KW'(ref_cnt_q)] <= bus.ref_q;
        end
        if (sig_we) begin
            sig_i_buf[SIW'(sig_cnt_q)] <= bus.sig_i;
            sig_q_buf[SIW'(sig_cnt_q)] <= bus.sig_q;
        end
    end

    // Next state, load counters, (s,k) walk and the registered output pair
    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = ref_cnt_q;
        sig_cnt_d  = sig_cnt_q;
        s_d        = s_q;
        k_d        = k_q;
        valid_d    = valid_q;
        sig_rd_idx = '0;

        case (state_q)
            ST_LOAD: begin
                if (ref_we) ref_cnt_d = ref_cnt_q + RCW'(1);
                if (sig_we) sig_cnt_d = sig_cnt_q + SCW'(1);
                if ((ref_cnt_q == REF_FULL) && (sig_cnt_q == SIG_FULL)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (start) begin
                    state_d = ST_STREAM;
                    s_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_DONE;
                            s_d     = '0;
                            valid_d = 1'b0;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DONE: begin
                ref_cnt_d = '0;
                sig_cnt_d = '0;
                state_d   = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase

        // treadys are registered from the next state so they are low in reset
        ref_tready_d = (state_d == ST_LOAD) && (ref_cnt_d < REF_FULL);
        sig_tready_d = (state_d == ST_LOAD) && (sig_cnt_d < SIG_FULL);

        // Buffers are frozen outside LOAD, so re-reading (s,k) while stalled holds the pair
        sig_rd_idx = SIW'(s_d) + SIW'(k_d);
        if (valid_d) begin
            xi_d = ref_i_buf[k_d];
            xq_d = ref_q_buf[k_d];
            yi_d = sig_i_buf[sig_rd_idx];
            yq_d = sig_q_buf[sig_rd_idx];
        end else begin
            xi_d = '0;
            xq_d = '0;
            yi_d = '0;
            yq_d = '0;
        end
    end

    // State and control registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            ref_cnt_q    <= '0;
            sig_cnt_q    <= '0;
            ref_tready_q <= 1'b0;
            sig_tready_q <= 1'b0;
            s_q          <= '0;
            k_q          <= '0;
            valid_q      <= 1'b0;
            xi_q         <= '0;
            xq_q         <= '0;
            yi_q         <= '0;
            yq_q         <= '0;
        end else begin
            state_q      <= state_d;
            ref_cnt_q    <= ref_cnt_d;
            sig_cnt_q    <= sig_cnt_d;
            ref_tready_q <= ref_tready_d;
            sig_tready_q <= sig_tready_d;
            s_q          <= s_d;
            k_q          <= k_d;
            valid_q      <= valid_d;
            xi_q         <= xi_d;
            xq_q         <= xq_d;
            yi_q         <= yi_d;
            yq_q         <= yq_d;
        end
    end

    // Output drive straight from flops; last/busy/done are decoded flop values
    always_comb begin
        bus.s_axis_ref_tready = ref_tready_q;
        bus.s_axis_sig_tready = sig_tready_q;
        bus.m_axis_x_tvalid   = valid_q;
        bus.m_axis_y_tvalid   = valid_q;
        bus.xi                = xi_q;
        bus.xq                = xq_q;
        bus.yi                = yi_q;
        bus.yq                = yq_q;
        bus.shift_index       = s_q;
        bus.last              = valid_q && (k_q == K_LAST);
        busy                  = (state_q == ST_STREAM);
        done                  = (state_q == ST_DONE);
    end
endmodule

// File: tb/tb_dot_prod_feeder.sv
// tb/tb_dot_prod_feeder.sv - directed table-driven bench for dot_prod_feeder
module tb_dot_prod_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic busy_a, done_a;
    logic start_b = 1'b0;
    logic busy_b, done_b;

    int n_pass = 0;
    int n_total = 0;
    int ref_idx = 0;
    int sig_idx = 0;

    always #5 clk = ~clk;

    dot_prod_feeder_if #(.shifts(4)) a_if ();
    dot_prod_feeder_if #(.shifts(1)) b_if ();

    dot_prod_feeder #(.length(5), .shifts(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(a_if.master)
    );
    dot_prod_feeder #(.length(2), .shifts(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(b_if.master)
    );

    typedef struct {
        logic [2:0]  sh;
        logic [11:0] xi, xq, yi, yq;
        logic        last;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both sample streams until ref_idx/sig_idx reach the requested counts
    task automatic load_a(input int ref_n, input int sig_n, input bit gaps);
        bit rf, sf;
        int cyc = 0;
        while ((ref_idx < ref_n || sig_idx < sig_n) && cyc < 200) begin
            a_if.s_axis_ref_tvalid = (ref_idx < ref_n);
            a_if.ref_i = 12'(ref_idx + 1);
            a_if.ref_q = 12'(ref_idx + 1);
            a_if.s_axis_sig_tvalid = (sig_idx < sig_n) && (!gaps || (cyc % 2 == 0));
            a_if.sig_i = 12'(10 + sig_idx);
            a_if.sig_q = 12'd0;
            rf = a_if.s_axis_ref_tvalid && a_if.s_axis_ref_tready;
            sf = a_if.s_axis_sig_tvalid && a_if.s_axis_sig_tready;
            tick();
            if (rf) ref_idx++;
            if (sf) sig_idx++;
            cyc++;
        end
        a_if.s_axis_ref_tvalid = 1'b0;
        a_if.s_axis_sig_tvalid = 1'b0;
        if (cyc >= 200) chk("load_timeout", 64'(cyc), 64'(0));
    endtask

    // Start from READY and check every pair, holds, last and the done pulse
    task automatic run_stream(input bit toggle, input int abort_at);
        int p = 0;
        bit seen_done = 0;
        bit tr, acc;
        chk("pre_start_valid", a_if.m_axis_x_tvalid, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("valid_latency1", a_if.m_axis_x_tvalid, 1);
        chk("busy_stream", busy_a, 1);
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (p == abort_at) return;
            if (p < 20) begin
                chk("valid_held", a_if.m_axis_x_tvalid, 1);
                chk("y_valid_eq_x", a_if.m_axis_y_tvalid, a_if.m_axis_x_tvalid);
                chk($sformatf("pair%0d", p),
                    {a_if.shift_index, a_if.xi, a_if.xq, a_if.yi, a_if.yq, a_if.last},
                    {tbl[p].sh, tbl[p].xi, tbl[p].xq, tbl[p].yi, tbl[p].yq, tbl[p].last});
                chk("done_early", done_a, 0);
            end else begin
                seen_done = 1;
                chk("done_pulse", done_a, 1);
                chk("done_valid_low", a_if.m_axis_x_tvalid, 0);
                chk("done_data_zero", {a_if.xi, a_if.xq, a_if.yi, a_if.yq, a_if.last}, 0);
            end
            tr = toggle ? (cyc % 2 == 0) : 1'b1;
            a_if.m_axis_product_tready = tr;
            acc = a_if.m_axis_x_tvalid && tr;
            tick();
            if (acc) p++;
        end
        chk("done_seen", seen_done, 1);
        chk("done_one_cycle", done_a, 0);
        chk("idle_busy", busy_a, 0);
        chk("reload_treadys", {a_if.s_axis_ref_tready, a_if.s_axis_sig_tready}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 5; k++)
                tbl[s*5+k] = '{sh: 3'(s), xi: 12'(k+1), xq: 12'(k+1),
                               yi: 12'(10+s+k), yq: 12'd0, last: (k == 4)};

        a_if.s_axis_ref_tvalid = 0; a_if.ref_i = 0; a_if.ref_q = 0;
        a_if.s_axis_sig_tvalid = 0; a_if.sig_i = 0; a_if.sig_q = 0;
        a_if.m_axis_product_tready = 0;
        b_if.s_axis_ref_tvalid = 0; b_if.ref_i = 0; b_if.ref_q = 0;
        b_if.s_axis_sig_tvalid = 0; b_if.sig_i = 0; b_if.sig_q = 0;
        b_if.m_axis_product_tready = 0;

        // reset state
        tick(); tick();
        chk("rst_valid", a_if.m_axis_x_tvalid, 0);
        chk("rst_outs", {a_if.xi, a_if.xq, a_if.yi, a_if.yq, a_if.shift_index, a_if.last, busy_a, done_a}, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_treadys", {a_if.s_axis_ref_tready, a_if.s_axis_sig_tready}, 2'b11);

        // 1: parallel load, tready held high
        ref_idx = 0; sig_idx = 0;
        load_a(5, 8, 0);
        tick();
        chk("ready_treadys", {a_if.s_axis_ref_tready, a_if.s_axis_sig_tready, busy_a}, 0);
        run_stream(0, -1);

        // 2: same load, tready toggling 1,0,1,0
        ref_idx = 0; sig_idx = 0;
        load_a(5, 8, 0);
        tick();
        run_stream(1, -1);

        // 3: sig first with gaps, extra sig beat refused, then ref
        ref_idx = 0; sig_idx = 0;
        load_a(0, 8, 1);
        chk("sig_full_tready", a_if.s_axis_sig_tready, 0);
        chk("ref_open_tready", a_if.s_axis_ref_tready, 1);
        a_if.s_axis_sig_tvalid = 1'b1; a_if.sig_i = 12'd99;
        chk("ninth_sig_tready", a_if.s_axis_sig_tready, 0);
        tick();
        a_if.s_axis_sig_tvalid = 1'b0;
        load_a(4, 8, 0);
        tick();
        chk("not_ready_4ref", a_if.s_axis_ref_tready, 1);
        load_a(5, 8, 0);
        chk("ref_full_tready", a_if.s_axis_ref_tready, 0);
        tick();
        run_stream(0, -1);

        // 4: start in LOAD is ignored
        ref_idx = 0; sig_idx = 0;
        load_a(3, 8, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("start_in_load_busy", busy_a, 0);
        chk("start_in_load_valid", a_if.m_axis_x_tvalid, 0);
        chk("start_in_load_tready", a_if.s_axis_ref_tready, 1);
        load_a(5, 8, 0);
        tick();
        run_stream(0, -1);

        // 5: asynchronous reset at pair s=1,k=3
        ref_idx = 0; sig_idx = 0;
        load_a(5, 8, 0);
        tick();
        run_stream(0, 8);
        chk("pre_abort_pair", {a_if.shift_index, a_if.xi, a_if.yi}, {3'd1, 12'd4, 12'd14});
        rst_n = 1'b0;
        #1;
        chk("abort_async_outs", {a_if.m_axis_x_tvalid, a_if.xi, a_if.xq, a_if.yi, a_if.yq,
                                 a_if.shift_index, a_if.last, busy_a, done_a}, 0);
        tick();
        rst_n = 1'b1;
        chk("abort_no_done", done_a, 0);
        tick();
        chk("abort_treadys", {a_if.s_axis_ref_tready, a_if.s_axis_sig_tready}, 2'b11);
        chk("abort_still_no_done", {done_a, busy_a}, 0);

        // 6: length=2, shifts=1 instance
        for (int i = 0; i < 20 && (b_if.s_axis_ref_tvalid !== 1'b0 || i == 0 || b_if.s_axis_ref_tready); i++) begin
            if (i >= 2) break;
            b_if.s_axis_ref_tvalid = 1'b1; b_if.ref_i = 12'(i + 1); b_if.ref_q = 12'(i + 1);
            b_if.s_axis_sig_tvalid = 1'b1; b_if.sig_i = 12'(10 + i); b_if.sig_q = 12'd0;
            chk($sformatf("b_load_tready%0d", i), {b_if.s_axis_ref_tready, b_if.s_axis_sig_tready}, 2'b11);
            tick();
        end
        b_if.s_axis_ref_tvalid = 1'b0;
        b_if.s_axis_sig_tvalid = 1'b0;
        chk("b_full_treadys", {b_if.s_axis_ref_tready, b_if.s_axis_sig_tready}, 0);
        tick();
        b_if.m_axis_product_tready = 1'b1;
        start_b = 1'b1;
        chk("b_pre_valid", b_if.m_axis_x_tvalid, 0);
        tick();
        start_b = 1'b0;
        chk("b_pair0", {b_if.m_axis_x_tvalid, b_if.shift_index, b_if.xi, b_if.xq, b_if.yi, b_if.yq, b_if.last},
            {1'b1, 1'b0, 12'd1, 12'd1, 12'd10, 12'd0, 1'b0});
        tick();
        chk("b_pair1", {b_if.m_axis_x_tvalid, b_if.shift_index, b_if.xi, b_if.xq, b_if.yi, b_if.yq, b_if.last},
            {1'b1, 1'b0, 12'd2, 12'd2, 12'd11, 12'd0, 1'b1});
        chk("b_no_done_yet", done_b, 0);
        tick();
        chk("b_done", {done_b, b_if.m_axis_x_tvalid, busy_b}, 3'b100);
        tick();
        chk("b_done_drop", {done_b, b_if.m_axis_x_tvalid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
